// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package regfile_ctrl_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned GRANT_W = 2;

    localparam int unsigned REQ_ALU  = 0;
    localparam int unsigned REQ_LOAD = 1;
    localparam int unsigned REQ_DBG  = 2;

    localparam logic [GRANT_W-1:0] GRANT_INIT = 2'd3;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin one-hot selection starting at the pointer.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [PTR_W-1:0]   grant_idx_c
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // Search ptr, ptr+1, ... with wrap-around; first valid requester wins.
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        found       = 1'b0;
        idx         = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((32'(ptr) + k) % NUM_REQ);
            if (!found && valid[idx]) begin
                found        = 1'b1;
                grant_c[idx] = 1'b1;
                grant_idx_c  = idx;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 8x16 RegisterFile: zeroing sweep after reset,
// then round-robin grants of one write per cycle.
module regfile_write_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = regfile_ctrl_pkg::DATA_W,
    parameter int unsigned ADDR_W  = regfile_ctrl_pkg::ADDR_W,
    parameter int unsigned NUM_REQ = regfile_ctrl_pkg::NUM_REQ
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          ReqValid,
    input  logic [NUM_REQ*ADDR_W-1:0]   ReqAddr,
    input  logic [NUM_REQ*DATA_W-1:0]   ReqData,
    output logic [NUM_REQ-1:0]          ReqReady,
    output logic                        Busy,
    output logic [ADDR_W-1:0]           Address3,
    output logic                        WE,
    output logic [DATA_W-1:0]           WriteData,
    output logic [1:0]                  GrantId
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic                we_d;
    logic                busy_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   data_d;
    logic [1:0]          gid_d;

    logic [NUM_REQ-1:0]  grant_c;
    logic [PTR_W-1:0]    grant_idx_c;

    logic [ADDR_W-1:0]   req_addr [NUM_REQ];
    logic [DATA_W-1:0]   req_data [NUM_REQ];

    // Unpack the flat requester buses into per-requester slices.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_addr[i] = ReqAddr[i*ADDR_W +: ADDR_W];
        assign req_data[i] = ReqData[i*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .valid       (ReqValid),
        .ptr         (ptr_q),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, combinational grant and next values of the output registers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        we_d     = 1'b0;
        busy_d   = Busy;
        addr_d   = Address3;
        data_d   = WriteData;
        gid_d    = GrantId;
        ReqReady = '0;
        unique case (state_q)
            ST_INIT: begin
                we_d   = 1'b1;
                addr_d = cnt_q;
                data_d = '0;
                gid_d  = GRANT_INIT;
                cnt_d  = cnt_q + ADDR_W'(1);
                if (&cnt_q) begin
                    state_d = ST_ARB;
                    busy_d  = 1'b0;
                end
            end
            ST_ARB: begin
                ReqReady = grant_c;
                if (|(ReqValid & grant_c)) begin
                    we_d   = 1'b1;
                    addr_d = req_addr[grant_idx_c];
                    data_d = req_data[grant_idx_c];
                    gid_d  = 2'(grant_idx_c);
                    ptr_d  = (grant_idx_c == PTR_W'(NUM_REQ - 1)) ? '0
                                                                  : grant_idx_c + PTR_W'(1);
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Sweep counter, pointer and registered write-port outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            ptr_q     <= '0;
            WE        <= 1'b0;
            Busy      <= 1'b1;
            Address3  <= '0;
            WriteData <= '0;
            GrantId   <= GRANT_INIT;
        end else begin
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            WE        <= we_d;
            Busy      <= busy_d;
            Address3  <= addr_d;
            WriteData <= data_d;
            GrantId   <= gid_d;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a behavioural register file.
module tb_regfile_write_arbiter;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned NUM_REQ = 3;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        ReqValid;
    logic [NUM_REQ*ADDR_W-1:0] ReqAddr;
    logic [NUM_REQ*DATA_W-1:0] ReqData;
    logic [NUM_REQ-1:0]        ReqReady;
    logic                      Busy;
    logic [ADDR_W-1:0]         Address3;
    logic                      WE;
    logic [DATA_W-1:0]         WriteData;
    logic [1:0]                GrantId;

    logic [DATA_W-1:0] rf [8];

    int n_tests = 0;
    int n_fail  = 0;

    regfile_write_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .ReqValid  (ReqValid),
        .ReqAddr   (ReqAddr),
        .ReqData   (ReqData),
        .ReqReady  (ReqReady),
        .Busy      (Busy),
        .Address3  (Address3),
        .WE        (WE),
        .WriteData (WriteData),
        .GrantId   (GrantId)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file stand-in: commits on the edge after WE is driven.
    always @(posedge clk) begin
        if (WE) rf[Address3] <= WriteData;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] v,
                           input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2,
                           input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
        ReqValid = v;
        ReqAddr  = {a2, a1, a0};
        ReqData  = {d2, d1, d0};
    endtask

    // Sweep check: n edges, each registering address i with zero data.
    task automatic sweep_edges(input int n, input logic [2:0] ready_exp_during);
        for (int i = 0; i < n; i++) begin
            check("init_ready", 32'(ReqReady), 32'(ready_exp_during));
            tick();
            check("init_we",   32'(WE), 32'd1);
            check("init_addr", 32'(Address3), 32'(i));
            check("init_data", 32'(WriteData), 32'd0);
            check("init_gid",  32'(GrantId), 32'd3);
            check("init_busy", 32'(Busy), (i < 7) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        logic [2:0]  exp_addr [3];
        logic [15:0] exp_data [3];
        exp_addr[0] = 3'd1; exp_addr[1] = 3'd2; exp_addr[2] = 3'd4;
        exp_data[0] = 16'h1111; exp_data[1] = 16'h2222; exp_data[2] = 16'h4444;

        for (int i = 0; i < 8; i++) rf[i] = 16'hDEAD;
        rst = 1'b1;
        set_req(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
        tick();
        tick();

        // Reset state
        check("rst_we",    32'(WE), 32'd0);
        check("rst_addr",  32'(Address3), 32'd0);
        check("rst_data",  32'(WriteData), 32'd0);
        check("rst_busy",  32'(Busy), 32'd1);
        check("rst_ready", 32'(ReqReady), 32'd0);
        check("rst_gid",   32'(GrantId), 32'd3);

        // Initialisation sweep
        rst = 1'b0;
        sweep_edges(8, 3'b000);
        tick();
        check("post_init_we", 32'(WE), 32'd0);
        for (int i = 0; i < 8; i++) check("sweep_zero", 32'(rf[i]), 32'd0);

        // Single write from the load unit
        set_req(3'b010, 3'd0, 3'd3, 3'd0, 16'h0, 16'd25, 16'h0);
        #1;
        check("load_ready", 32'(ReqReady), 32'b010);
        tick();
        set_req(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
        check("load_we",   32'(WE), 32'd1);
        check("load_addr", 32'(Address3), 32'd3);
        check("load_data", 32'(WriteData), 32'd25);
        check("load_gid",  32'(GrantId), 32'd1);
        tick();
        check("load_rf3", 32'(rf[3]), 32'd25);
        check("idle_we",  32'(WE), 32'd0);

        // Pointer is at 2: lone debug write brings it back to 0
        set_req(3'b100, 3'd0, 3'd0, 3'd6, 16'h0, 16'h0, 16'h0006);
        #1;
        check("dbg_ready", 32'(ReqReady), 32'b100);
        tick();
        set_req(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
        check("dbg_gid", 32'(GrantId), 32'd2);

        // All three continuously valid: grants 0,1,2,0,1,2 with no gap
        set_req(3'b111, 3'd1, 3'd2, 3'd4, 16'h1111, 16'h2222, 16'h4444);
        for (int c = 0; c < 6; c++) begin
            #1;
            check("rr_ready", 32'(ReqReady), 32'(3'b001 << (c % 3)));
            tick();
            check("rr_we",   32'(WE), 32'd1);
            check("rr_gid",  32'(GrantId), 32'(c % 3));
            check("rr_addr", 32'(Address3), 32'(exp_addr[c % 3]));
            check("rr_data", 32'(WriteData), 32'(exp_data[c % 3]));
        end
        set_req(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
        tick();
        check("rr_rf1", 32'(rf[1]), 32'h1111);
        check("rr_rf2", 32'(rf[2]), 32'h2222);
        check("rr_rf4", 32'(rf[4]), 32'h4444);
        check("rr_rf6", 32'(rf[6]), 32'h0006);

        // Same address from ALU and debug: both writes, later grant wins
        set_req(3'b101, 3'd5, 3'd0, 3'd5, 16'hAAAA, 16'h0, 16'h5555);
        #1;
        check("same_ready0", 32'(ReqReady), 32'b001);
        tick();
        check("same_gid0",  32'(GrantId), 32'd0);
        check("same_data0", 32'(WriteData), 32'hAAAA);
        ReqValid = 3'b100;
        #1;
        check("same_ready1", 32'(ReqReady), 32'b100);
        tick();
        ReqValid = 3'b000;
        check("same_we1",   32'(WE), 32'd1);
        check("same_gid1",  32'(GrantId), 32'd2);
        check("same_addr1", 32'(Address3), 32'd5);
        check("same_data1", 32'(WriteData), 32'h5555);
        tick();
        check("same_rf5", 32'(rf[5]), 32'h5555);

        // Reset pulsed mid-sweep at address 4
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
        sweep_edges(5, 3'b000);
        #2 rst = 1'b1;
        #1;
        check("midsweep_we",   32'(WE), 32'd0);
        check("midsweep_addr", 32'(Address3), 32'd0);
        check("midsweep_busy", 32'(Busy), 32'd1);
        tick();
        check("midsweep_rf3", 32'(rf[3]), 32'd0);
        check("midsweep_rf4", 32'(rf[4]), 32'h4444);

        // Requests held through a restarted sweep, granted in the first ARB cycle
        set_req(3'b111, 3'd1, 3'd2, 3'd4, 16'hB001, 16'hB002, 16'hB004);
        rst = 1'b0;
        sweep_edges(8, 3'b000);
        check("first_arb_ready", 32'(ReqReady), 32'b001);
        tick();
        check("first_arb_gid",  32'(GrantId), 32'd0);
        check("first_arb_addr", 32'(Address3), 32'd1);
        check("first_arb_data", 32'(WriteData), 32'hB001);
        tick();
        check("arb2_gid", 32'(GrantId), 32'd1);

        // Reset during continuous arbitration drops the in-flight write
        #2 rst = 1'b1;
        #1;
        check("midarb_we",    32'(WE), 32'd0);
        check("midarb_ready", 32'(ReqReady), 32'd0);
        check("midarb_gid",   32'(GrantId), 32'd3);
        check("midarb_busy",  32'(Busy), 32'd1);
        tick();
        check("midarb_rf1", 32'(rf[1]), 32'hB001);
        check("midarb_rf2", 32'(rf[2]), 32'd0);
        check("midarb_rf4", 32'(rf[4]), 32'd0);
        set_req(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
        rst = 1'b0;
        sweep_edges(2, 3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
